// File: rtl/cic_pkg.sv
// Shared definitions for the CIC rate-change blocks (upsampler / downsampler).
package cic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cic_state_e;

    localparam int unsigned CIC_R_MIN = 2;
    localparam int unsigned CIC_R_MAX = 256;

    // Phase/decimation counter width for a given rate; never narrower than 1 bit.
    function automatic int unsigned cic_cnt_width(input int unsigned r);
        return (r < 2) ? 1 : int'($clog2(r));
    endfunction

endpackage

// File: rtl/upsampler.sv
// Interpolating upsampler: each accepted sample becomes CIC_R output beats,
// phase 0 carries the sample, later phases carry zero or a repeat of it.
module upsampler
    import cic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_INP = 8,
    parameter int unsigned CIC_R          = 4,
    parameter bit          HOLD_MODE      = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [DATA_WIDTH_INP-1:0] s_axis_in_tdata,
    input  logic                             s_axis_in_tvalid,
    output logic                             s_axis_in_tready,
    output logic signed [DATA_WIDTH_INP-1:0] m_axis_out_tdata,
    output logic                             m_axis_out_tvalid,
    input  logic                             m_axis_out_tready
);

    localparam int unsigned PW = cic_cnt_width(CIC_R);
    localparam logic [PW-1:0] LAST_PHASE = PW'(CIC_R - 1);

    // Reject unsupported parameterisations at elaboration.
    if (CIC_R < CIC_R_MIN || CIC_R > CIC_R_MAX) begin : g_bad_cic_r
        $error("upsampler: CIC_R=%0d outside supported range 2..256", CIC_R);
    end
    if (DATA_WIDTH_INP < 2 || DATA_WIDTH_INP > 32) begin : g_bad_width
        $error("upsampler: DATA_WIDTH_INP=%0d outside supported range 2..32", DATA_WIDTH_INP);
    end

    cic_state_e                      state_q, state_d;
    logic [PW-1:0]                   phase_q, phase_d;
    logic signed [DATA_WIDTH_INP-1:0] sample_q, sample_d;
    logic signed [DATA_WIDTH_INP-1:0] tdata_q, tdata_d;

    logic last_phase;
    logic out_xfer;
    logic in_ready;
    logic in_xfer;

    // Next-state, handshake and output-beat selection.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sample_d   = sample_q;
        tdata_d    = tdata_q;
        last_phase = (phase_q == LAST_PHASE);
        out_xfer   = (state_q == BUSY) && m_axis_out_tready;
        in_ready   = 1'b0;
        in_xfer    = 1'b0;

        // Accept in IDLE, or while the final phase is leaving this cycle.
        case (state_q)
            IDLE:    in_ready = 1'b1;
            BUSY:    in_ready = last_phase && m_axis_out_tready;
            default: in_ready = 1'b0;
        endcase
        if (reset) begin
            in_ready = 1'b0;
        end
        in_xfer = s_axis_in_tvalid && in_ready;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d  = BUSY;
                    phase_d  = '0;
                    sample_d = s_axis_in_tdata;
                    tdata_d  = s_axis_in_tdata;
                end
            end
            BUSY: begin
                if (out_xfer) begin
                    if (!last_phase) begin
                        phase_d = phase_q + PW'(1);
                        tdata_d = HOLD_MODE ? sample_q : '0;
                    end else if (in_xfer) begin
                        // Back-to-back sample: no bubble between bursts.
                        phase_d  = '0;
                        sample_d = s_axis_in_tdata;
                        tdata_d  = s_axis_in_tdata;
                    end else begin
                        state_d = IDLE;
                        phase_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // State, phase counter, held sample and output data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            sample_q <= '0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            tdata_q  <= tdata_d;
        end
    end

    assign s_axis_in_tready  = in_ready;
    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tvalid = (state_q == BUSY);

endmodule

// File: tb/tb_upsampler.sv
// Self-checking bench for upsampler: three configurations, directed steps plus
// a random handshake stress, with a scoreboard of expected output beats.
module tb_upsampler;

    localparam int unsigned DW = 8;
    localparam int unsigned ND = 3;
    localparam int R0 = 4;
    localparam int R1 = 3;
    localparam int R2 = 5;

    logic clk = 1'b0;
    logic reset;

    logic signed [DW-1:0] s_tdata  [ND];
    logic                 s_tvalid [ND];
    logic                 s_tready [ND];
    logic signed [DW-1:0] m_tdata  [ND];
    logic                 m_tvalid [ND];
    logic                 m_tready [ND];

    int n_vec = 0;
    int n_err = 0;
    int beats [ND];

    logic signed [DW-1:0] exp_q [$];
    logic signed [DW-1:0] exp_v;
    logic                 hold_prev [ND];
    logic signed [DW-1:0] data_prev [ND];

    int s1_dat [8] = '{5, 0, 0, 0, -3, 0, 0, 0};

    always #5 clk = ~clk;

    // R=4 zero-stuffing
    upsampler #(.DATA_WIDTH_INP(DW), .CIC_R(R0), .HOLD_MODE(1'b0)) u_r4 (
        .clk(clk), .reset(reset),
        .s_axis_in_tdata(s_tdata[0]), .s_axis_in_tvalid(s_tvalid[0]), .s_axis_in_tready(s_tready[0]),
        .m_axis_out_tdata(m_tdata[0]), .m_axis_out_tvalid(m_tvalid[0]), .m_axis_out_tready(m_tready[0])
    );

    // R=3 sample-and-hold
    upsampler #(.DATA_WIDTH_INP(DW), .CIC_R(R1), .HOLD_MODE(1'b1)) u_r3h (
        .clk(clk), .reset(reset),
        .s_axis_in_tdata(s_tdata[1]), .s_axis_in_tvalid(s_tvalid[1]), .s_axis_in_tready(s_tready[1]),
        .m_axis_out_tdata(m_tdata[1]), .m_axis_out_tvalid(m_tvalid[1]), .m_axis_out_tready(m_tready[1])
    );

    // R=5 zero-stuffing (non-power-of-2)
    upsampler #(.DATA_WIDTH_INP(DW), .CIC_R(R2), .HOLD_MODE(1'b0)) u_r5 (
        .clk(clk), .reset(reset),
        .s_axis_in_tdata(s_tdata[2]), .s_axis_in_tvalid(s_tvalid[2]), .s_axis_in_tready(s_tready[2]),
        .m_axis_out_tdata(m_tdata[2]), .m_axis_out_tvalid(m_tvalid[2]), .m_axis_out_tready(m_tready[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, when handshakes for the next edge are settled.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) hold_prev[d] = 1'b0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (hold_prev[d]) begin
                    n_vec++;
                    assert (m_tvalid[d] === 1'b1 && m_tdata[d] === data_prev[d]) else begin
                        n_err++;
                        $error("FAIL hold_stable dut%0d: observed valid=%b data=%0d expected valid=1 data=%0d",
                               d, m_tvalid[d], m_tdata[d], data_prev[d]);
                    end
                end
                hold_prev[d] = m_tvalid[d] && !m_tready[d];
                data_prev[d] = m_tdata[d];

                if (m_tvalid[d] && m_tready[d]) begin
                    beats[d]++;
                    n_vec++;
                    assert (exp_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL extra_beat dut%0d: observed data=%0d expected no beat", d, m_tdata[d]);
                    end
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        n_vec++;
                        assert (m_tdata[d] === exp_v) else begin
                            n_err++;
                            $error("FAIL beat_data dut%0d: observed %0d expected %0d", d, m_tdata[d], exp_v);
                        end
                    end
                end

                if (s_tvalid[d] && s_tready[d]) begin
                    int rr;
                    bit hh;
                    case (d)
                        0:       begin rr = R0; hh = 1'b0; end
                        1:       begin rr = R1; hh = 1'b1; end
                        default: begin rr = R2; hh = 1'b0; end
                    endcase
                    for (int p = 0; p < rr; p++)
                        exp_q.push_back((p == 0 || hh) ? s_tdata[d] : DW'(0));
                end
            end

            n_vec++;
            assert (int'(u_r5.phase_q) < R2) else begin
                n_err++;
                $error("FAIL phase_range r5: observed %0d expected < %0d", u_r5.phase_q, R2);
            end
        end
    end

    initial begin
        int base;
        int nacc;
        logic acc;

        reset = 1'b1;
        for (int d = 0; d < ND; d++) begin
            s_tvalid[d]  = 1'b0;
            s_tdata[d]   = '0;
            m_tready[d]  = 1'b1;
            beats[d]     = 0;
            hold_prev[d] = 1'b0;
        end
        repeat (2) tick();
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_tvalid", 32'(m_tvalid[d]), 0);
            chk("rst_tdata", 32'(m_tdata[d]), 0);
            chk("rst_s_tready", 32'(s_tready[d]), 0);
        end
        reset = 1'b0;
        tick();

        // Scenario 1: R=4 zero-stuff, 5 then -3 back-to-back
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 5;
        #1;
        chk("s1_idle_s_tready", 32'(s_tready[0]), 1);
        chk("s1_idle_tvalid", 32'(m_tvalid[0]), 0);
        tick();
        s_tdata[0] = -3;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) s_tvalid[0] = 1'b0;
            #1;
            chk("s1_tvalid", 32'(m_tvalid[0]), 1);
            chk("s1_tdata", 32'(m_tdata[0]), s1_dat[i]);
            chk("s1_s_tready", 32'(s_tready[0]), (i % 4 == 3) ? 1 : 0);
            tick();
        end
        #1;
        chk("s1_idle_after", 32'(m_tvalid[0]), 0);

        // Scenario 2: R=3 hold mode, single sample 7
        s_tvalid[1] = 1'b1;
        s_tdata[1]  = 7;
        #1;
        chk("s2_idle_s_tready", 32'(s_tready[1]), 1);
        tick();
        s_tvalid[1] = 1'b0;
        s_tdata[1]  = -100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s2_tvalid", 32'(m_tvalid[1]), 1);
            chk("s2_tdata", 32'(m_tdata[1]), 7);
            tick();
        end
        #1;
        chk("s2_idle_after", 32'(m_tvalid[1]), 0);

        // Scenario 3: R=4, sample 9 with downstream ready toggling
        m_tready[0] = 1'b0;
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 9;
        tick();
        s_tvalid[0] = 1'b0;
        s_tdata[0]  = 55;
        base = beats[0];
        for (int i = 0; i < 8; i++) begin
            m_tready[0] = (i % 2 == 1);
            #1;
            chk("s3_tvalid", 32'(m_tvalid[0]), 1);
            chk("s3_tdata", 32'(m_tdata[0]), (i < 2) ? 9 : 0);
            tick();
        end
        #1;
        chk("s3_idle_after", 32'(m_tvalid[0]), 0);
        chk("s3_transfers", beats[0] - base, 4);
        m_tready[0] = 1'b1;

        // Scenario 4: R=5, three samples streamed
        base        = beats[2];
        nacc        = 0;
        s_tvalid[2] = 1'b1;
        s_tdata[2]  = 11;
        for (int c = 0; c < 60 && nacc < 3; c++) begin
            #1;
            acc = s_tvalid[2] && s_tready[2];
            tick();
            if (acc) begin
                nacc++;
                if (nacc < 3) s_tdata[2] = DW'(11 + nacc);
                else          s_tvalid[2] = 1'b0;
            end
        end
        chk("s4_accepted", nacc, 3);
        for (int c = 0; c < 40 && m_tvalid[2]; c++) tick();
        #1;
        chk("s4_idle_after", 32'(m_tvalid[2]), 0);
        chk("s4_beats", beats[2] - base, 15);

        // Scenario 5: R=4 stream 1..4, reset one cycle after phase 1 of sample 4
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 1;
        tick();
        for (int c = 0; c < 14; c++) begin
            if (c % 4 == 0) begin
                if (c / 4 + 1 < 4) s_tdata[0] = DW'(c / 4 + 2);
                else               s_tvalid[0] = 1'b0;
            end
            #1;
            chk("s5_stream_tdata", 32'(m_tdata[0]), (c % 4 == 0) ? (c / 4 + 1) : 0);
            tick();
        end
        reset = 1'b1;
        tick();
        #1;
        chk("s5_rst_tvalid", 32'(m_tvalid[0]), 0);
        chk("s5_rst_s_tready", 32'(s_tready[0]), 0);
        chk("s5_rst_tdata", 32'(m_tdata[0]), 0);
        reset = 1'b0;
        exp_q.delete();
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 6;
        tick();
        s_tvalid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s5_post_tvalid", 32'(m_tvalid[0]), 1);
            chk("s5_post_tdata", 32'(m_tdata[0]), (i == 0) ? 6 : 0);
            tick();
        end
        #1;
        chk("s5_post_idle", 32'(m_tvalid[0]), 0);

        // Scenario 6: R=5 random valid/ready stress, 1000 samples
        base        = beats[2];
        nacc        = 0;
        s_tvalid[2] = 1'b0;
        for (int c = 0; c < 30000 && nacc < 1000; c++) begin
            m_tready[2] = ($urandom_range(0, 9) < 6);
            if (!s_tvalid[2] && $urandom_range(0, 9) < 7) begin
                s_tvalid[2] = 1'b1;
                s_tdata[2]  = DW'($urandom);
            end
            #1;
            acc = s_tvalid[2] && s_tready[2];
            tick();
            if (acc) begin
                nacc++;
                s_tvalid[2] = 1'b0;
            end
        end
        s_tvalid[2] = 1'b0;
        m_tready[2] = 1'b1;
        for (int c = 0; c < 40 && m_tvalid[2]; c++) tick();
        #1;
        chk("s6_accepted", nacc, 1000);
        chk("s6_beats", beats[2] - base, 1000 * R2);
        chk("s6_scoreboard_empty", exp_q.size(), 0);
        chk("s6_idle_after", 32'(m_tvalid[2]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/upsampler.md
UPSAMPLER -- requirements
Module: upsampler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_INP, default 8: sample width in bits, signed, range 2..32.
REQ-002 The block SHALL have parameter CIC_R, default 4: interpolation ratio, range 2..256; values outside this range SHALL cause an elaboration error.
REQ-003 The block SHALL have parameter HOLD_MODE, default 0: 0 = zero-stuffing, 1 = sample-and-hold.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port s_axis_in_tdata, input, DATA_WIDTH_INP bits: signed input sample.
REQ-007 The block SHALL have port s_axis_in_tvalid, input, 1 bit: input sample valid.
REQ-008 The block SHALL have port s_axis_in_tready, output, 1 bit: block can accept an input sample.
REQ-009 The block SHALL have port m_axis_out_tdata, output, DATA_WIDTH_INP bits: signed output sample, registered.
REQ-010 The block SHALL have port m_axis_out_tvalid, output, 1 bit: output beat valid, registered.
REQ-011 The block SHALL have port m_axis_out_tready, input, 1 bit: downstream accepts the output beat.

Function
REQ-012 An input transfer SHALL occur on a rising edge with s_axis_in_tvalid && s_axis_in_tready; an output transfer SHALL occur with m_axis_out_tvalid && m_axis_out_tready.
REQ-013 Each accepted input sample SHALL produce exactly CIC_R output beats, numbered phase 0..CIC_R-1, in order.
REQ-014 Phase 0 SHALL carry the input sample; phases 1..CIC_R-1 SHALL carry 0 when HOLD_MODE=0 and the same input sample when HOLD_MODE=1.
REQ-015 The block SHALL have two states: IDLE (no beat pending, m_axis_out_tvalid=0) and BUSY (beat pending, m_axis_out_tvalid=1).
REQ-016 In IDLE, s_axis_in_tready SHALL be 1; an input transfer SHALL move to BUSY with phase 0 on m_axis_out_tdata on the next cycle (latency 1 cycle).
REQ-017 In BUSY, an output transfer at phase p < CIC_R-1 SHALL advance to phase p+1 on the next cycle; without an output transfer, tdata, tvalid and the phase counter SHALL hold unchanged.
REQ-018 s_axis_in_tready SHALL be 1 in BUSY only when the phase is CIC_R-1 and m_axis_out_tready=1; this is a combinational path from m_axis_out_tready.
REQ-019 At phase CIC_R-1 with an output transfer and a simultaneous input transfer, the block SHALL present phase 0 of the new sample on the next cycle with no bubble, giving 100% output duty under continuous input.
REQ-020 At phase CIC_R-1 with an output transfer and no input transfer, the block SHALL return to IDLE and m_axis_out_tvalid SHALL fall on the next cycle.
REQ-021 The phase counter SHALL be $clog2(CIC_R) bits wide, SHALL wrap from CIC_R-1 to 0, and SHALL never exceed CIC_R-1, including for non-power-of-2 CIC_R.
REQ-022 Input data SHALL be captured only on an input transfer; s_axis_in_tdata changes at other times SHALL have no effect.
REQ-023 Output data SHALL be passed through without arithmetic change: no gain, rounding or width change.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL clear state to IDLE, the phase counter to 0, m_axis_out_tvalid to 0, m_axis_out_tdata to 0 and the held sample to 0.
REQ-025 s_axis_in_tready SHALL be 0 while reset is asserted.
REQ-026 Reset asserted mid-burst SHALL discard the remaining phases; after release, the first accepted sample SHALL start again at phase 0.

Structure
REQ-027 Package cic_pkg SHALL hold the state enum (IDLE, BUSY) and the function computing counter width from CIC_R; the downsampler and this block SHALL share it.
REQ-028 The block SHALL be a single module with no sub-module; total RTL SHALL be about 120-200 lines.

Verification
REQ-029 Scenario 1: CIC_R=4, HOLD_MODE=0, m_tready=1, inputs 5, -3 back-to-back -> outputs 5,0,0,0,-3,0,0,0 on consecutive cycles, with s_tready high on the first cycle and on each phase-3 cycle.
REQ-030 Scenario 2: HOLD_MODE=1, CIC_R=3, input 7 -> outputs 7,7,7, then tvalid=0 when no further input.
REQ-031 Scenario 3: CIC_R=4, input 9, m_tready toggling 1,0,1,0 -> each beat held stable while m_tready=0, and exactly 4 transfers of 9,0,0,0.
REQ-032 Scenario 4: CIC_R=5 (non-power-of-2), 3 samples -> exactly 15 output beats, and the phase counter never reaches 5.
REQ-033 Scenario 5: reset asserted one cycle after phase 1 of sample 4 -> next cycle tvalid=0 and s_tready=0; after release, input 6 yields 6,0,0,0.
REQ-034 Scenario 6: random valid/ready stress with 1000 samples against a reference model -> output count = 1000*CIC_R, with zero mismatches and no beat lost or duplicated.
